// File: rtl/window3x3_gen_pkg.sv
// Shared video constants for the 3x3 window generator and its line buffers.
package window3x3_gen_pkg;

  // Pixel format (RGB444) and default frame geometry.
  localparam int PIX_WIDTH     = 12;
  localparam int IMG_W_DEFAULT = 640;
  localparam int IMG_H_DEFAULT = 480;

  // Window geometry, row-major indices: 0..2 top row, 3..5 middle, 6..8 bottom.
  localparam int WIN_SIZE      = 3;
  localparam int WIN_TAPS      = WIN_SIZE * WIN_SIZE;
  localparam int WIN_CENTRE    = 4;
  localparam int WIN_TOP_RIGHT = 2;
  localparam int WIN_MID_RIGHT = 5;
  localparam int WIN_BOT_RIGHT = 8;

  // A window exists only once two earlier rows and columns have been seen.
  localparam int WIN_FIRST_POS = 2;

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// One video line of storage: synchronous read, separate write port,
// read-before-write when both ports hit the same address. No reset so it
// maps onto block RAM.
module line_buffer
  import window3x3_gen_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEFAULT,
  parameter int WIDTH = PIX_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Registered read returns the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Buffers the two previous rows and
// emits a window (centre at col-1,row-1) for every interior pixel position.
// Stage 1 registers the accepted pixel and its position and reads both line
// buffers; stage 2 shifts the window and publishes it.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] win0,
  output logic [WIDTH-1:0] win1,
  output logic [WIDTH-1:0] win2,
  output logic [WIDTH-1:0] win3,
  output logic [WIDTH-1:0] win4,
  output logic [WIDTH-1:0] win5,
  output logic [WIDTH-1:0] win6,
  output logic [WIDTH-1:0] win7,
  output logic [WIDTH-1:0] win8,
  output logic             win_valid,
  output logic [COL_W-1:0] cx,
  output logic [ROW_W-1:0] cy
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_FIRST_POS);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_FIRST_POS);

  logic [COL_W-1:0] col, eff_col, s1_col;
  logic [ROW_W-1:0] row, eff_row, s1_row;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_pix;
  logic [WIDTH-1:0] lb0_q, lb1_q;
  logic [WIDTH-1:0] win_q    [WIN_TAPS];
  logic [WIDTH-1:0] win_next [WIN_TAPS];
  logic [WIDTH-1:0] win_out  [WIN_TAPS];
  logic             win_hit;

  // sof forces the accepted pixel to (0,0), overriding any wrap in progress.
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (sof) begin
      eff_col = '0;
      eff_row = '0;
    end
  end

  // Raster position of the next pixel; wraps per line and per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col <= eff_col + COL_W'(1);
        row <= eff_row;
      end
    end
  end

  // Stage 1: capture the accepted pixel alongside its resolved position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_pix <= pix_in;
        s1_col <= eff_col;
        s1_row <= eff_row;
      end
    end
  end

  // LB0 holds row y-1: read the old word and overwrite it with the new pixel.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb0 (
    .clk     (clk),
    .rd_en   (pix_valid),
    .rd_addr (eff_col),
    .rd_data (lb0_q),
    .wr_en   (pix_valid),
    .wr_addr (eff_col),
    .wr_data (pix_in)
  );

  // LB1 holds row y-2. The word LB0 displaced only appears one cycle after
  // the read, so LB1 is written from stage 1 at the registered column; that
  // column is never read again until a full line later.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(WIDTH)) u_lb1 (
    .clk     (clk),
    .rd_en   (pix_valid),
    .rd_addr (eff_col),
    .rd_data (lb1_q),
    .wr_en   (s1_valid),
    .wr_addr (s1_col),
    .wr_data (lb0_q)
  );

  // Next window: every row moves one column left, new right column enters.
  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++) begin
      win_next[r*WIN_SIZE]     = win_q[r*WIN_SIZE + 1];
      win_next[r*WIN_SIZE + 1] = win_q[r*WIN_SIZE + 2];
      win_next[r*WIN_SIZE + 2] = win_q[r*WIN_SIZE + 2];
    end
    win_next[WIN_TOP_RIGHT] = lb1_q;
    win_next[WIN_MID_RIGHT] = lb0_q;
    win_next[WIN_BOT_RIGHT] = s1_pix;
  end

  // Interior positions only; rows 0-1 and cols 0-1 (including those after a
  // frame wrap or sof) never produce a window, which also hides stale RAM.
  always_comb begin
    win_hit = s1_valid && (s1_row >= ROW_FIRST) && (s1_col >= COL_FIRST);
  end

  // Stage 2: window shift register advances once per accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else if (s1_valid) begin
      win_q <= win_next;
    end
  end

  // Stage 2: outputs update only on a strobe and otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_out[i] <= '0;
      end
      win_valid <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        win_out <= win_next;
        cx      <= s1_col - COL_W'(1);
        cy      <= s1_row - ROW_W'(1);
      end
    end
  end

  assign win0 = win_out[0];
  assign win1 = win_out[1];
  assign win2 = win_out[2];
  assign win3 = win_out[3];
  assign win4 = win_out[WIN_CENTRE];
  assign win5 = win_out[5];
  assign win6 = win_out[6];
  assign win7 = win_out[7];
  assign win8 = win_out[8];

endmodule
